seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples of (an, seg) needed before a capture; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: cycles without a capture on a digit before that digit's valid bit clears; legal range 2..2^24.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seg  input  7  multiplexed segment bus, active-low; seg[0]=a through seg[6]=g.
REQ-006 an  input  4  digit anode enables, active-low; an[i]=0 selects digit i.
REQ-007 digits  output  16  captured codes; digits[4i+3:4i] is digit i.
REQ-008 digit_valid  output  4  bit i high while digits[4i+3:4i] holds a fresh capture.
REQ-009 frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse or reset.
REQ-010 err  output  1  one-cycle pulse on a stable but unrecognised segment pattern or an illegal anode pattern.

Function
REQ-011 seg and an SHALL be registered through a 2-flop synchroniser; all behaviour below is defined on the synchronised values, adding 2 cycles of latency.
REQ-012 Decode table, seg[6:0] hex: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F->F (blank); every other pattern SHALL be unrecognised.
REQ-013 FSM states: IDLE, SETTLE, CAPTURE.
REQ-014 IDLE: when an has exactly one bit low, SHALL load the stability counter with 1, latch (an, seg), and go to SETTLE; an=4'hF SHALL stay in IDLE without error.
REQ-015 SETTLE: each cycle (an, seg) equals the latched value, the counter SHALL increment; when it reaches STABLE_CYCLES, go to CAPTURE.
REQ-016 SETTLE: any change in (an, seg) SHALL relatch the new value, reload the counter with 1, and stay in SETTLE, or go to IDLE if an no longer has exactly one bit low.
REQ-017 CAPTURE, one cycle, recognised pattern on digit i: write the code to digits[4i+3:4i], set digit_valid[i], set frame mask bit i, and reload digit i's timeout counter.
REQ-018 CAPTURE, unrecognised pattern: digits and digit_valid SHALL be unchanged and err SHALL pulse; the mask bit SHALL NOT be set.
REQ-019 From CAPTURE, SHALL go to a wait condition (held in SETTLE with the counter saturated) until (an, seg) changes; the same pattern SHALL NOT be recaptured while held.
REQ-020 More than one an bit low, stable for STABLE_CYCLES, SHALL pulse err once and capture nothing.
REQ-021 When the frame mask reaches 4'hF, frame_done SHALL pulse in the cycle after the completing capture, and the mask SHALL clear in that same cycle.
REQ-022 Each digit's timeout counter SHALL count while its valid bit is set; on reaching TIMEOUT_CYCLES it SHALL clear digit_valid[i] but leave the digits value unchanged.
REQ-023 If a capture and a timeout hit the same digit in the same cycle, the capture SHALL win.
REQ-024 Counters SHALL saturate, never wrap.

Reset
REQ-025 On reset=1 at a clock edge, the following SHALL apply in the same cycle:
- digits=16'hFFFF, digit_valid=0, frame_done=0, err=0;
- mask, counters and synchronisers cleared (synchroniser an=4'hF, seg=7'h7F);
- FSM to IDLE.
REQ-026 Reset asserted mid-SETTLE or mid-CAPTURE SHALL abort the operation with no capture, err or frame_done pulse.

Structure
REQ-027 The following belong in a shared seven-segment package, reused by the display drivers:
- FSM state enum;
- decode-table constants (SEG_0..SEG_9, SEG_BLANK);
- BLANK_CODE=4'hF.
REQ-028 The pattern-to-code lookup SHALL be a combinational sub-module, seg_pattern_decode (in: seg[6:0]; out: code[3:0], hit), instantiated once.

Verification
REQ-029 Reset, then drive an=E, seg=30 for 10 cycles -> digits[3:0]=3 and digit_valid=0001 at cycle 2+4+1, exactly one capture, err=0.
REQ-030 Scan an=E,D,B,7 with seg=79,24,30,19, 8 cycles each -> digits=16'h4321, digit_valid=F, one frame_done pulse after the fourth capture.
REQ-031 Glitch: an=E, seg=40 for 3 cycles, then 12 for 6 cycles -> only 5 captured, never 0.
REQ-032 an=E, seg=55 held 8 cycles -> one err pulse, digits unchanged, digit_valid[0] unchanged.
REQ-033 an=C, seg=00 held 8 cycles -> one err pulse, no capture.
REQ-034 TIMEOUT_CYCLES=16, capture digit 2, then an=F -> digit_valid[2] clears 16 cycles after capture, digits[11:8] retained; reset asserted during SETTLE -> no capture.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// Shared seven-segment definitions: scan FSM states, active-low segment patterns
// and small anode helpers used by the display drivers.
package seg_scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } scan_state_e;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [AN_W-1:0]   AN_NONE    = 4'hF;
  localparam logic [CODE_W-1:0] BLANK_CODE = 4'hF;

  // Active-low patterns, seg[0]=a .. seg[6]=g
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  function automatic logic one_low(input logic [AN_W-1:0] an);
    return ($countones(~an) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [AN_W-1:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < int'(AN_W); i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// Combinational lookup from an active-low segment pattern to its hex code.
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  output logic [CODE_W-1:0] code,
  output logic              hit
);

  always_comb begin
    code = BLANK_CODE;
    hit  = 1'b1;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_BLANK: code = BLANK_CODE;
      default:   hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four digit codes from a multiplexed, active-low 7-segment scan bus,
// with debounce, per-digit staleness timeout, frame completion and error pulses.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEG_W-1:0]  seg,
  input  logic [AN_W-1:0]   an,
  output logic [15:0]       digits,
  output logic [AN_W-1:0]   digit_valid,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

  logic [AN_W-1:0]   r_an_s1, r_an_s2, r_lat_an, w_lat_an_nxt;
  logic [SEG_W-1:0]  r_seg_s1, r_seg_s2, r_lat_seg, w_lat_seg_nxt;
  scan_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic              r_held, w_held_nxt;
  logic              w_same;
  logic [CODE_W-1:0] w_code;
  logic              w_hit;
  logic              w_cap_ok, w_cap_err;
  logic [1:0]        w_cap_idx;
  logic [AN_W-1:0]   w_cap_bit, w_mask_base, r_mask;
  logic [TO_W-1:0]   r_to_cnt [AN_W];

  // Two-flop synchroniser; idle values match an undriven display
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_s1  <= AN_NONE;
      r_an_s2  <= AN_NONE;
      r_seg_s1 <= SEG_BLANK;
      r_seg_s2 <= SEG_BLANK;
    end else begin
      r_an_s1  <= an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
    end
  end

  seg_pattern_decode u_decode (
    .seg  (r_lat_seg),
    .code (w_code),
    .hit  (w_hit)
  );

  assign w_same    = (r_an_s2 == r_lat_an) && (r_seg_s2 == r_lat_seg);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Any active anode (even several) is tracked so illegal stable patterns can be flagged
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_held_nxt    = r_held;
    w_lat_an_nxt  = r_lat_an;
    w_lat_seg_nxt = r_lat_seg;
    case (r_state)
      ST_IDLE: begin
        if (r_an_s2 != AN_NONE) begin
          w_lat_an_nxt  = r_an_s2;
          w_lat_seg_nxt = r_seg_s2;
          w_cnt_nxt     = CNT_W'(1);
          w_held_nxt    = 1'b0;
          w_state_nxt   = (STABLE_CYCLES == 1) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!w_same) begin
          w_held_nxt = 1'b0;
          if (r_an_s2 == AN_NONE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_lat_an_nxt  = r_an_s2;
            w_lat_seg_nxt = r_seg_s2;
            w_cnt_nxt     = CNT_W'(1);
            w_state_nxt   = (STABLE_CYCLES == 1) ? ST_CAPTURE : ST_SETTLE;
          end
        end else if (!r_held) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= STABLE_N) w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_cnt_nxt   = CNT_MAX;
        w_held_nxt  = 1'b1;
        w_state_nxt = ST_SETTLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_held    <= 1'b0;
      r_lat_an  <= AN_NONE;
      r_lat_seg <= SEG_BLANK;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_held    <= w_held_nxt;
      r_lat_an  <= w_lat_an_nxt;
      r_lat_seg <= w_lat_seg_nxt;
    end
  end

  assign w_cap_ok    = (r_state == ST_CAPTURE) && one_low(r_lat_an) && w_hit;
  assign w_cap_err   = (r_state == ST_CAPTURE) && !w_cap_ok;
  assign w_cap_idx   = low_index(r_lat_an);
  assign w_cap_bit   = w_cap_ok ? (4'b0001 << w_cap_idx) : '0;
  assign w_mask_base = (r_mask == 4'hF) ? '0 : r_mask;

  // Capture outranks a same-cycle timeout on the same digit
  always_ff @(posedge clk) begin
    if (reset) begin
      digits      <= {4{BLANK_CODE}};
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      r_mask      <= '0;
      for (int i = 0; i < int'(AN_W); i++) r_to_cnt[i] <= '0;
    end else begin
      frame_done <= (r_mask == 4'hF);
      err        <= w_cap_err;
      r_mask     <= w_mask_base | w_cap_bit;
      for (int i = 0; i < int'(AN_W); i++) begin
        if (w_cap_ok && (w_cap_idx == 2'(i))) begin
          digits[4*i +: 4] <= w_code;
          digit_valid[i]   <= 1'b1;
          r_to_cnt[i]      <= '0;
        end else if (digit_valid[i]) begin
          if (r_to_cnt[i] >= TO_LAST) digit_valid[i] <= 1'b0;
          else                        r_to_cnt[i]    <= r_to_cnt[i] + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed-vector bench for seg_scan_decoder with a queue-based scoreboard on output events.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits_a, digits_b;
  logic [3:0]  valid_a, valid_b;
  logic        fd_a, fd_b, err_a, err_b;

  always #5 clk = ~clk;

  seg_scan_decoder dut_a (
    .clk(clk), .reset(reset), .seg(seg), .an(an),
    .digits(digits_a), .digit_valid(valid_a), .frame_done(fd_a), .err(err_a)
  );

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .seg(seg), .an(an),
    .digits(digits_b), .digit_valid(valid_b), .frame_done(fd_b), .err(err_b)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [15:0] d;
    logic [3:0]  v;
    logic        fd;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic expect_ev(input string nm, input int c, input logic [15:0] d,
                           input logic [3:0] v, input logic fd, input logic e);
    exp_t x;
    x.name = nm; x.cyc = c; x.d = d; x.v = v; x.fd = fd; x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_digits_a"}, 32'(digits_a), 32'hFFFF);
    chk({tag, "_valid_a"},  32'(valid_a),  32'h0);
    chk({tag, "_fd_a"},     32'(fd_a),     32'h0);
    chk({tag, "_err_a"},    32'(err_a),    32'h0);
    chk({tag, "_digits_b"}, 32'(digits_b), 32'hFFFF);
    chk({tag, "_valid_b"},  32'(valid_b),  32'h0);
  endtask

  // Monitor: any change of digits/valid, or any pulse, is an event to match against the queue
  initial begin : monitor
    logic [15:0] pd;
    logic [3:0]  pv;
    logic        rst_e;
    exp_t        x;
    pd = 16'hFFFF;
    pv = 4'h0;
    forever begin
      @(posedge clk);
      cyc++;
      rst_e = reset;
      #1;
      if (rst_e) begin
        pd = digits_a;
        pv = valid_a;
      end else if (digits_a !== pd || valid_a !== pv || fd_a !== 1'b0 || err_a !== 1'b0) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got cyc=%0d digits=%h valid=%b fd=%b err=%b, required no event",
                   cyc, digits_a, valid_a, fd_a, err_a);
        end else begin
          x = exp_q.pop_front();
          if (x.cyc == cyc && x.d === digits_a && x.v === valid_a && x.fd === fd_a && x.e === err_a)
            n_pass++;
          else
            $display("FAIL %s: got cyc=%0d digits=%h valid=%b fd=%b err=%b, required cyc=%0d digits=%h valid=%b fd=%b err=%b",
                     x.name, cyc, digits_a, valid_a, fd_a, err_a, x.cyc, x.d, x.v, x.fd, x.e);
        end
        pd = digits_a;
        pv = valid_a;
      end
    end
  end

  initial begin : stimulus
    int k;
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset("init");

    // Single digit: capture lands 2 sync + 4 stable + 1 capture cycles after the drive
    k = cyc;
    expect_ev("single_d0_3", k + 7, 16'hFFF3, 4'b0001, 1'b0, 1'b0);
    drive(4'hE, 7'h30, 10);
    drive(4'hF, 7'h7F, 6);

    // Full scan; frame_done one cycle after the fourth capture
    k = cyc;
    expect_ev("scan_d0_1",  k + 7,  16'hFFF1, 4'b0001, 1'b0, 1'b0);
    expect_ev("scan_d1_2",  k + 15, 16'hFF21, 4'b0011, 1'b0, 1'b0);
    expect_ev("scan_d2_3",  k + 23, 16'hF321, 4'b0111, 1'b0, 1'b0);
    expect_ev("scan_d3_4",  k + 31, 16'h4321, 4'b1111, 1'b0, 1'b0);
    expect_ev("scan_frame", k + 32, 16'h4321, 4'b1111, 1'b1, 1'b0);
    drive(4'hE, 7'h79, 8);
    drive(4'hD, 7'h24, 8);
    drive(4'hB, 7'h30, 8);
    drive(4'h7, 7'h19, 8);
    drive(4'hF, 7'h7F, 6);

    // Glitch: 3 cycles of "0" are too short, only the following "5" is captured
    do_reset(2);
    check_reset("rst_glitch");
    k = cyc;
    expect_ev("glitch_5", k + 10, 16'hFFF5, 4'b0001, 1'b0, 1'b0);
    drive(4'hE, 7'h40, 3);
    drive(4'hE, 7'h12, 6);
    drive(4'hF, 7'h7F, 6);

    // Unrecognised pattern and illegal anode: one err each, nothing else moves
    k = cyc;
    expect_ev("bad_seg_err", k + 7, 16'hFFF5, 4'b0001, 1'b0, 1'b1);
    drive(4'hE, 7'h55, 8);
    drive(4'hF, 7'h7F, 6);
    k = cyc;
    expect_ev("multi_an_err", k + 7, 16'hFFF5, 4'b0001, 1'b0, 1'b1);
    drive(4'hC, 7'h00, 8);
    drive(4'hF, 7'h7F, 6);

    // Blank is a legal code; err above must not have set mask bits
    k = cyc;
    expect_ev("blank_d1",   k + 7,  16'hFFF5, 4'b0011, 1'b0, 1'b0);
    expect_ev("six_d2",     k + 15, 16'hF6F5, 4'b0111, 1'b0, 1'b0);
    expect_ev("seven_d3",   k + 23, 16'h76F5, 4'b1111, 1'b0, 1'b0);
    expect_ev("fill_frame", k + 24, 16'h76F5, 4'b1111, 1'b1, 1'b0);
    drive(4'hD, 7'h7F, 8);
    drive(4'hB, 7'h02, 8);
    drive(4'h7, 7'h78, 8);
    drive(4'hF, 7'h7F, 6);

    // Timeout on the short-timeout instance; default instance keeps its valid bit
    do_reset(2);
    check_reset("rst_timeout");
    k = cyc;
    expect_ev("to_d2_capture", k + 7, 16'hF2FF, 4'b0100, 1'b0, 1'b0);
    drive(4'hB, 7'h24, 7);
    chk("to_b_valid_at_capture", 32'(valid_b), 32'h4);
    chk("to_b_digit_at_capture", 32'(digits_b[11:8]), 32'h2);
    drive(4'hB, 7'h24, 1);
    drive(4'hF, 7'h7F, 14);
    chk("to_b_valid_before", 32'(valid_b), 32'h4);
    drive(4'hF, 7'h7F, 1);
    chk("to_b_valid_cleared", 32'(valid_b), 32'h0);
    chk("to_b_digit_retained", 32'(digits_b[11:8]), 32'h2);
    chk("to_a_valid_kept", 32'(valid_a), 32'h4);

    // Reset one cycle before the capture would land: nothing may be captured
    k = cyc;
    drive(4'hE, 7'h30, 5);
    do_reset(1);
    check_reset("rst_abort");
    drive(4'hF, 7'h7F, 12);
    chk("abort_digits_a", 32'(digits_a), 32'hFFFF);
    chk("abort_valid_a",  32'(valid_a),  32'h0);
    chk("abort_valid_b",  32'(valid_b),  32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
